// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Transmit stage that drains a byte FIFO with a registered read port. While
// the FIFO reports not-empty it pops one byte, sends it as an 8N1 / 8N2
// asynchronous frame (start bit, 8 data bits LSB first, stop bit(s)), and
// repeats until the FIFO runs dry.
//
// Handshake with the FIFO: rd is a registered one-cycle pop request raised
// only from IDLE after empty=0 was sampled; the FIFO samples rd on the next
// edge and presents the byte on r_data one cycle later, where LOAD captures
// it. empty is only looked at in IDLE.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous reset, active low
//   empty        in   FIFO empty flag
//   r_data[7:0]  in   FIFO read data (registered inside the FIFO)
//   rd           out  FIFO pop request, single-cycle pulse
//   tx           out  serial line, idle high, driven straight from a flop
//   busy         out  high whenever the FSM is not in IDLE
//   tx_done      out  one-cycle pulse after the last stop bit completes
//   dbg_state_o  out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       empty,
   input  logic [7:0] r_data,
   output logic       rd,
   output logic       tx,
   output logic       busy,
   output logic       tx_done,
   output logic [2:0] dbg_state_o
);

   // One counter serves both the per-bit timing and the (possibly longer)
   // stop period, so it is sized for the longest of the two.
   localparam int CNT_MAX = CLKS_PER_BIT * STOP_BITS;
   localparam int CNT_W   = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CNT_MAX - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_POP   = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_START = 3'd3;
   localparam logic [2:0] S_DATA  = 3'd4;
   localparam logic [2:0] S_STOP  = 3'd5;

   logic [2:0]       state_q, state_d;
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tx_q, tx_d;
   logic             rd_q, rd_d;
   logic             done_q, done_d;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      cnt_d     = cnt_q;
      tx_d      = tx_q;
      rd_d      = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               rd_d    = 1'b1;
               state_d = S_POP;
            end
         end

         // The FIFO consumes rd at this edge; its data shows up next cycle.
         S_POP: begin
            state_d = S_LOAD;
         end

         S_LOAD: begin
            shift_d = r_data;
            tx_d    = 1'b0;
            cnt_d   = '0;
            state_d = S_START;
         end

         S_START: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d     = '0;
               tx_d      = shift_q[0];
               bit_idx_d = 3'd0;
               state_d   = S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  // tx takes the bit that becomes shift[0] after the shift.
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_STOP: begin
            if (cnt_q == STOP_LAST) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         shift_q   <= 8'h00;
         bit_idx_q <= 3'd0;
         cnt_q     <= '0;
         tx_q      <= 1'b1;
         rd_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         cnt_q     <= cnt_d;
         tx_q      <= tx_d;
         rd_q      <= rd_d;
         done_q    <= done_d;
      end
   end

   assign rd          = rd_q;
   assign tx          = tx_q;
   assign tx_done     = done_q;
   assign busy        = (state_q != S_IDLE);
   assign dbg_state_o = state_q;

endmodule
